spi_flash_responder: RTL and testbench

SPI-target counterpart to the on-chip flash controller: emulates a serial NOR flash on the slave side of a mode-0 SPI link. It decodes the opcode, address and dummy phases and serves read data fetched qword-wise from an internal 64-bit memory port. It also returns status and JEDEC ID bytes. Used as a flash stand-in (BIOS image in RAM) and as the loopback target for controller verification.

---
 rtl/spi_resp_pkg.sv | 13 +
 rtl/spi_resp_sync.sv | 36 +++
 rtl/spi_flash_responder.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg: states, opcodes and byte-lane helper shared by the SPI flash responder.
package spi_resp_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, STAT, ID, IGNORE} state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    function automatic logic [7:0] byte_lane(input logic [63:0] q, input logic [2:0] k);
        return q[{k, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: SYNC_STAGES-deep synchronizers for SCK/SCS/SDI plus SCK rise/fall detect.
module spi_resp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sck,
    input  logic i_scs,
    input  logic i_sdi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_scs,
    output logic o_sdi
);
    logic [SYNC_STAGES-1:0] r_sck, r_scs, r_sdi;
    logic r_sck_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck   <= '0;
            r_scs   <= '1;
            r_sdi   <= '0;
            r_sck_d <= 1'b0;
        end else begin
            r_sck   <= {r_sck[SYNC_STAGES-2:0], i_sck};
            r_scs   <= {r_scs[SYNC_STAGES-2:0], i_scs};
            r_sdi   <= {r_sdi[SYNC_STAGES-2:0], i_sdi};
            r_sck_d <= r_sck[SYNC_STAGES-1];
        end
    end

    assign o_sck_rise = r_sck[SYNC_STAGES-1] & ~r_sck_d;
    assign o_sck_fall = ~r_sck[SYNC_STAGES-1] & r_sck_d;
    assign o_scs      = r_scs[SYNC_STAGES-1];
    assign o_sdi      = r_sdi[SYNC_STAGES-1];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI NOR flash emulator serving reads from a 64-bit memory port.
// Define SPI_RESP_JEDEC_EN to build the 9F (JEDEC ID) response.
module spi_flash_responder
    import spi_resp_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_clkh,
    input  logic        i_reset,
    input  logic        i_sck,
    input  logic        i_scs,
    input  logic        i_sdi,
    output logic        o_sdo,
    output logic        o_sdo_oe,
    output logic        o_act,
    output logic [20:0] o_addr,
    input  logic        i_next,
    input  logic        i_drdy,
    input  logic [63:0] i_dti,
    input  logic [7:0]  i_status,
    output logic        o_busy,
    output logic        o_underrun
);
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [6:0]  r_sh;
    logic        r_fast;
    logic [23:0] r_baddr;
    logic [7:0]  r_obyte;
    logic [2:0]  r_obit;
    logic        r_load;
    logic [63:0] r_cur, r_nxt;
    logic        r_cur_v, r_nxt_v;
    logic        r_wait;
    logic [1:0]  r_stale;
`ifdef SPI_RESP_JEDEC_EN
    logic [23:0] r_id;
`endif

    logic   w_rise, w_fall, w_scs, w_sdi;
    logic   [7:0] w_op, w_byte;
    state_t w_dec;
    logic   w_a21, w_step, w_acc, w_drop, w_done;

    spi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clkh),
        .i_rst      (i_reset),
        .i_sck      (i_sck),
        .i_scs      (i_scs),
        .i_sdi      (i_sdi),
        .o_sck_rise (w_rise),
        .o_sck_fall (w_fall),
        .o_scs      (w_scs),
        .o_sdi      (w_sdi)
    );

    assign w_op  = {r_sh, w_sdi};
    assign w_dec = (w_op == OP_READ || w_op == OP_FREAD) ? ADDR :
                   (w_op == OP_RDSR) ? STAT :
`ifdef SPI_RESP_JEDEC_EN
                   (w_op == OP_RDID) ? ID :
`endif
                   IGNORE;
    assign w_byte = (r_state == DATA) ? (r_cur_v ? byte_lane(r_cur, r_baddr[2:0]) : 8'hFF) :
`ifdef SPI_RESP_JEDEC_EN
                    (r_state == ID) ? r_id[23:16] :
`endif
                    i_status;

    assign w_a21  = ~w_scs & w_rise & (r_state == ADDR) & (r_cnt == 5'd20);
    assign w_step = ~w_scs & w_fall & (r_state == DATA) & (r_obit == 3'd7) & (r_baddr[2:0] == 3'd7);
    assign w_acc  = o_act & i_next;
    // memory returns in order, so the oldest outstanding stale fetch owns the next DRDY
    assign w_drop = i_drdy & (r_stale != 2'd0);
    assign w_done = i_drdy & (r_stale == 2'd0) & r_wait;

    always_ff @(posedge i_clkh or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_fast     <= 1'b0;
            r_baddr    <= '0;
            r_obyte    <= 8'hFF;
            r_obit     <= '0;
            r_load     <= 1'b0;
            o_sdo      <= 1'b1;
            o_sdo_oe   <= 1'b0;
            o_busy     <= 1'b0;
            o_underrun <= 1'b0;
`ifdef SPI_RESP_JEDEC_EN
            r_id       <= '0;
`endif
        end else begin
            o_busy <= ~w_scs;
            r_load <= 1'b0;
            if (r_load) begin
                r_obyte <= w_byte;
                if (r_state == DATA && !r_cur_v) o_underrun <= 1'b1;
`ifdef SPI_RESP_JEDEC_EN
                if (r_state == ID) r_id <= {r_id[15:0], 8'hFF};
`endif
            end
            if (w_scs) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                o_sdo    <= 1'b1;
                o_sdo_oe <= 1'b0;
                r_load   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= CMD;
                        r_cnt   <= '0;
                    end
                    CMD: if (w_rise) begin
                        r_sh  <= {r_sh[5:0], w_sdi};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd7) begin
                            r_state <= w_dec;
                            r_cnt   <= '0;
                            r_fast  <= (w_op == OP_FREAD);
                            r_obit  <= '0;
`ifdef SPI_RESP_JEDEC_EN
                            r_id    <= JEDEC_ID;
`endif
                            if (w_dec == STAT || w_dec == ID) begin
                                r_load   <= 1'b1;
                                o_sdo_oe <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (w_rise) begin
                        r_baddr <= {r_baddr[22:0], w_sdi};
                        r_cnt   <= r_cnt + 5'd1;
                        if (r_cnt == 5'd23) begin
                            r_cnt   <= '0;
                            r_state <= r_fast ? DUMMY : DATA;
                            if (!r_fast) begin
                                r_load   <= 1'b1;
                                o_sdo_oe <= 1'b1;
                            end
                        end
                    end
                    DUMMY: if (w_rise) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd7) begin
                            r_state  <= DATA;
                            r_load   <= 1'b1;
                            o_sdo_oe <= 1'b1;
                        end
                    end
                    DATA, STAT, ID: if (w_fall) begin
                        o_sdo   <= r_obyte[7];
                        r_obyte <= {r_obyte[6:0], 1'b1};
                        r_obit  <= r_obit + 3'd1;
                        if (r_obit == 3'd7) begin
                            r_load <= 1'b1;
                            if (r_state == DATA) r_baddr <= r_baddr + 24'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clkh or posedge i_reset) begin
        if (i_reset) begin
            r_cur   <= '0;
            r_nxt   <= '0;
            r_cur_v <= 1'b0;
            r_nxt_v <= 1'b0;
            o_act   <= 1'b0;
            o_addr  <= '0;
            r_wait  <= 1'b0;
            r_stale <= '0;
        end else begin
            r_stale <= r_stale + {1'b0, w_scs & ((r_wait & ~w_done) | w_acc)} - {1'b0, w_drop};
            if (w_scs) begin
                o_act   <= 1'b0;
                r_wait  <= 1'b0;
                r_cur_v <= 1'b0;
                r_nxt_v <= 1'b0;
            end else begin
                if (w_acc) begin
                    o_act  <= 1'b0;
                    r_wait <= 1'b1;
                end
                if (w_done) r_wait <= 1'b0;
                if (w_a21) begin
                    o_act  <= 1'b1;
                    o_addr <= {r_baddr[19:0], w_sdi};
                end else if (r_cur_v && !r_nxt_v && !o_act && !r_wait) begin
                    o_act  <= 1'b1;
                    o_addr <= o_addr + 21'd1;
                end
                if (w_step) begin
                    r_cur   <= r_nxt;
                    r_cur_v <= r_nxt_v;
                    r_nxt_v <= 1'b0;
                end
                if (w_done) begin
                    if (w_step ? r_nxt_v : r_cur_v) begin
                        r_nxt   <= i_dti;
                        r_nxt_v <= 1'b1;
                    end else begin
                        r_cur   <= i_dti;
                        r_cur_v <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: SPI initiator plus memory model; read bytes checked against a scoreboard.
module tb_spi_flash_responder;
    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        rst, sck, scs, sdi, next, drdy;
    logic [63:0] dti;
    logic [7:0]  status;
    logic        sdo, sdo_oe, act, busy, underrun;
    logic [20:0] addr;

    int n_chk = 0, n_err = 0;
    int cyc = 0, mem_lat = 3, act_cnt = 0, oe_cnt = 0;

    typedef struct {int due; logic [20:0] a;} req_t;
    req_t        mq[$];
    logic [20:0] acc_q[$];
    logic [7:0]  exp_q[$];

    spi_flash_responder dut (
        .i_clkh     (clk),
        .i_reset    (rst),
        .i_sck      (sck),
        .i_scs      (scs),
        .i_sdi      (sdi),
        .o_sdo      (sdo),
        .o_sdo_oe   (sdo_oe),
        .o_act      (act),
        .o_addr     (addr),
        .i_next     (next),
        .i_drdy     (drdy),
        .i_dti      (dti),
        .i_status   (status),
        .o_busy     (busy),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] qw(input logic [20:0] a);
        logic [63:0] q;
        for (int k = 0; k < 8; k++) q[8*k +: 8] = {a[4:0], 3'(k)};
        return q;
    endfunction

    // memory: byte[A] = A[7:0]; DRDY mem_lat cycles after each accepted request
    always @(negedge clk) begin
        cyc++;
        drdy = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            drdy = 1'b1;
            dti  = qw(mq[0].a);
            void'(mq.pop_front());
        end
        if (act && next) begin
            mq.push_back('{cyc + mem_lat, addr});
            acc_q.push_back(addr);
        end
        if (act) act_cnt++;
        if (sdo_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [31:0] d, input int n, output logic [31:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = d[i];
            repeat (HP) @(negedge clk);
            r = {r[30:0], sdo};
            sck = 1'b1;
            repeat (HP) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] d, input int n);
        logic [31:0] r;
        spi_bits(d, n, r);
    endtask

    task automatic got_byte(input logic [7:0] v);
        if (exp_q.size() == 0) check("sb_empty", exp_q.size(), 1);
        else check("rd", v, exp_q.pop_front());
    endtask

    task automatic rd(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            spi_bits(32'hFF, 8, r);
            got_byte(r[7:0]);
        end
    endtask

    task automatic cs_lo();
        scs = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic cs_hi();
        scs = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r1, r2;
        int a0, o0;
        rst = 1'b1; sck = 1'b0; scs = 1'b1; sdi = 1'b0; next = 1'b1;
        drdy = 1'b0; dti = '0; status = 8'h5A;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sdo", sdo, 1);
        check("rst_oe", sdo_oe, 0);
        check("rst_act", act, 0);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_unr", underrun, 0);

        cs_lo();
        send(32'h03000005, 32);
        for (int b = 5; b < 10; b++) exp_q.push_back(8'(b));
        rd(5);
        check("t1_busy", busy, 1);
        check("t1_oe", sdo_oe, 1);
        cs_hi();
        check("t1_oe_off", sdo_oe, 0);
        check("t1_unr", underrun, 0);

        acc_q.delete();
        cs_lo();
        send(32'h0BFFFFFE, 32);
        send(32'h0, 8);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        rd(4);
        cs_hi();
        check("t2_nacc", acc_q.size() >= 2, 1);
        if (acc_q.size() >= 2) begin
            check("t2_acc0", acc_q[0], 21'h1FFFFF);
            check("t2_acc1", acc_q[1], 21'h000000);
        end

        cs_lo();
        send(32'h05, 8);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        rd(2);
        spi_bits(32'hFF, 3, r1);
        status = 8'h3C;
        spi_bits(32'hFF, 5, r2);
        got_byte({r1[2:0], r2[4:0]});
        exp_q.push_back(8'h3C);
        rd(1);
        cs_hi();

        o0 = oe_cnt;
        cs_lo();
        send(32'h9F, 8);
`ifdef SPI_RESP_JEDEC_EN
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
        exp_q.push_back(8'h18); exp_q.push_back(8'hFF);
        rd(4);
`else
        for (int i = 0; i < 4; i++) send(32'hFF, 8);
        check("t4_no_oe", oe_cnt - o0, 0);
`endif
        cs_hi();

        mem_lat = 30;
        cs_lo();
        send(32'h03, 8);
        send(32'h8, 21);
        scs = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_act", act, 0);
        check("t5_oe", sdo_oe, 0);
        check("t5_busy", busy, 0);
        mem_lat = 3;
        cs_lo();
        send(32'h03000010, 32);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        rd(2);
        cs_hi();
        check("t5_unr", underrun, 0);

        next = 1'b0;
        cs_lo();
        send(32'h03000000, 32);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        rd(3);
        check("t6_act", act, 1);
        check("t6_addr", addr, 0);
        check("t6_unr", underrun, 1);
        cs_hi();
        check("t6_drop", act, 0);
        next = 1'b1;
        repeat (4) @(negedge clk);

        a0 = act_cnt;
        o0 = oe_cnt;
        cs_lo();
        send(32'h42, 8);
        send(32'hFFFF, 16);
        cs_hi();
        check("t7_act", act_cnt - a0, 0);
        check("t7_oe", oe_cnt - o0, 0);
        check("t7_unr_sticky", underrun, 1);

        check("sb_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
